// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - ROM requester port: request and response valid/ready channels
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Requester side (fetch unit or LSU)
  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares one combinational ROM between fetch and load ports (ROUND_ROBIN_EN selects round-robin)
module rom_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_arbiter_if.slave          if_port,
  rom_arbiter_if.slave          ld_port,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t                 if_slot;
  slot_t                 ld_slot;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] ld_data_q;
  logic                  if_elig;
  logic                  ld_elig;
  logic                  if_gnt;
  logic                  ld_gnt;

  // A port may take a new word when its slot is empty, or full but drained this cycle
  always_comb begin
    if_elig = rst_n & if_port.req_valid & ((if_slot == EMPTY) | if_port.rsp_ready);
    ld_elig = rst_n & ld_port.req_valid & ((ld_slot == EMPTY) | ld_port.rsp_ready);
  end

`ifdef ROUND_ROBIN_EN
  typedef enum logic {
    FAV_IF = 1'b0,
    FAV_LD = 1'b1
  } fav_t;

  fav_t fav;

  // Favoured port wins a tie; a lone eligible port always wins
  always_comb begin
    ld_gnt = ld_elig & (~if_elig | (fav == FAV_LD));
    if_gnt = if_elig & (~ld_elig | (fav == FAV_IF));
  end

  // Pointer moves away from whichever port was just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav <= FAV_IF;
    end else if (ld_gnt) begin
      fav <= FAV_IF;
    end else if (if_gnt) begin
      fav <= FAV_LD;
    end
  end
`else
  // Fixed priority: load always beats fetch
  always_comb begin
    ld_gnt = ld_elig;
    if_gnt = if_elig & ~ld_elig;
  end
`endif

  // Drive ROM address from the granted port, zero when idle
  always_comb begin
    rom_address = '0;
    if (ld_gnt) begin
      rom_address = ld_port.req_addr;
    end else if (if_gnt) begin
      rom_address = if_port.req_addr;
    end
  end

  // Handshake outputs: ready is the grant, response comes straight from the slot registers
  always_comb begin
    if_port.req_ready = if_gnt;
    ld_port.req_ready = ld_gnt;
    if_port.rsp_valid = (if_slot == FULL);
    ld_port.rsp_valid = (ld_slot == FULL);
    if_port.rsp_data  = if_data_q;
    ld_port.rsp_data  = ld_data_q;
  end

  // Response slot state per port: capture on grant, release when consumer takes the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_slot   <= EMPTY;
      ld_slot   <= EMPTY;
      if_data_q <= '0;
      ld_data_q <= '0;
    end else begin
      if (if_gnt) begin
        if_slot   <= FULL;
        if_data_q <= rom_data;
      end else if ((if_slot == FULL) && if_port.rsp_ready) begin
        if_slot <= EMPTY;
      end

      if (ld_gnt) begin
        ld_slot   <= FULL;
        ld_data_q <= rom_data;
      end else if ((ld_slot == FULL) && ld_port.rsp_ready) begin
        ld_slot <= EMPTY;
      end
    end
  end

endmodule
